// File: rtl/aes_key_expansion_ctrl.sv
// AES-128 key-schedule sequencer: steps the external KeySchedule core through NUM_ROUNDS rounds and banks round keys 0..NUM_ROUNDS.
// Optional build macro AES_KEY_REUSE_EN: a start with the key of the last completed run skips expansion.
module aes_key_expansion_ctrl #(
  parameter int NUM_ROUNDS     = 10,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic         busy,
  output logic         done,
  output logic         err,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data,
  output logic         rk_valid,
  output logic         ks_en,
  output logic         ks_sel,
  output logic [7:0]   ks_rcon,
  output logic [127:0] ks_key_in,
  input  logic         ks_key_flag,
  input  logic [127:0] ks_key
);
  localparam int DEPTH = NUM_ROUNDS + 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_CAPTURE, S_FIN} state_t;

  state_t           state_reg;
  logic [3:0]       round_reg;
  logic [TW-1:0]    timer_reg;
  logic [DEPTH-1:0] valid_reg;
  logic [127:0]     bank_reg [DEPTH];

  logic         start_full;
  logic         reuse_hit;
  logic         capture;
  logic         bank_we;
  logic [3:0]   bank_waddr;
  logic [127:0] bank_wdata;

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

`ifdef AES_KEY_REUSE_EN
  // All valid bits set only after a completed run, and bank[0] still holds that run's key.
  assign reuse_hit = start && (state_reg == S_IDLE) && (&valid_reg) && (cipher_key == bank_reg[0]);
`else
  assign reuse_hit = 1'b0;
`endif

  assign start_full = start && (state_reg == S_IDLE) && !reuse_hit;
  assign capture    = (state_reg == S_WAIT) && ks_key_flag;
  assign bank_we    = start_full || capture;
  assign bank_waddr = start_full ? 4'd0 : round_reg;
  assign bank_wdata = start_full ? cipher_key : ks_key;
  assign ks_sel     = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bank_reg[i] <= '0;
    end else if (bank_we) begin
      bank_reg[bank_waddr] <= bank_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      round_reg <= '0;
      timer_reg <= '0;
      valid_reg <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ks_en     <= 1'b0;
      ks_rcon   <= 8'h01;
      ks_key_in <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start_full) begin
            ks_key_in <= cipher_key;
            round_reg <= 4'd1;
            valid_reg <= DEPTH'(1);
            err       <= 1'b0;
            busy      <= 1'b1;
            state_reg <= S_LOAD;
          end else if (reuse_hit) begin
            err       <= 1'b0;
            done      <= 1'b1;
            state_reg <= S_FIN;
          end
        end
        // ks_en is low here so the core is back in its own idle before the first round.
        S_LOAD: begin
          ks_en     <= 1'b1;
          ks_rcon   <= rcon_of(round_reg);
          state_reg <= S_ISSUE;
        end
        S_ISSUE: begin
          timer_reg <= '0;
          state_reg <= S_WAIT;
        end
        // A flag arriving on the timeout cycle is still captured.
        S_WAIT: begin
          if (ks_key_flag) begin
            valid_reg[round_reg] <= 1'b1;
            ks_key_in            <= ks_key;
            ks_en                <= 1'b0;
            state_reg            <= S_CAPTURE;
          end else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            err       <= 1'b1;
            ks_en     <= 1'b0;
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        S_CAPTURE: begin
          if (round_reg == 4'(NUM_ROUNDS)) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= S_FIN;
          end else begin
            round_reg <= round_reg + 4'd1;
            ks_en     <= 1'b1;
            ks_rcon   <= rcon_of(round_reg + 4'd1);
            state_reg <= S_ISSUE;
          end
        end
        S_FIN:   state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rk_rd_data = '0;
    rk_valid   = 1'b0;
    if (rk_rd_idx < 4'(DEPTH)) begin
      rk_rd_data = bank_reg[rk_rd_idx];
      rk_valid   = valid_reg[rk_rd_idx];
    end
  end

endmodule
